// File: rtl/branch_resolve_unit.sv
// Resolves branches and SLT/SLTU results from the registered comparator flag and
// holds each result behind a valid/ready handshake to fetch/writeback.
module branch_resolve_unit #(
  parameter int unsigned IALIGN = 4,
  parameter int unsigned PC_INC = 4
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        dat_ready,
  input  logic [4:0]  decryptedOP,
  input  logic [31:0] cur_pc,
  input  logic [31:0] branch_imm,
  input  logic        Comparator_con_met,
  input  logic        out_ready,
  output logic        busy,
  output logic        out_valid,
  output logic        branch_taken,
  output logic        flush,
  output logic [31:0] next_pc,
  output logic        misalign_err,
  output logic        slt_wr_en,
  output logic [31:0] slt_result
);

  typedef enum logic [1:0] {StIdle, StWaitCmp, StValid} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_handled;
  logic        w_capture;
  logic        w_release;

  logic [4:0]  r_op;
  logic [31:0] r_pc;
  logic [31:0] r_imm;

  logic        r_taken;
  logic [31:0] r_next_pc;
  logic        r_misalign;
  logic        r_is_slt;
  logic        r_slt_bit;

  logic        w_is_branch;
  logic [31:0] w_target;
  logic [31:0] w_seq_pc;
  logic        w_mis_bits;
  logic        w_taken;
  logic        w_misalign;
  logic [31:0] w_next_pc;

  assign w_handled = (decryptedOP <= 5'd5) || (decryptedOP == 5'd9) || (decryptedOP == 5'd10);

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      StIdle: begin
        if (dat_ready && w_handled) begin
          w_capture    = 1'b1;
          w_state_next = StWaitCmp;
        end
      end
      StWaitCmp: w_state_next = StValid;
      StValid: begin
        // Requests arriving while the result is stalled are dropped, not buffered.
        if (out_ready) begin
          w_release = 1'b1;
          if (dat_ready && w_handled) begin
            w_capture    = 1'b1;
            w_state_next = StWaitCmp;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_op    <= 5'd0;
      r_pc    <= 32'd0;
      r_imm   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_op  <= decryptedOP;
        r_pc  <= cur_pc;
        r_imm <= branch_imm;
      end
    end
  end

  // Only handled ops are captured, so anything that is not a branch is SLT/SLTU.
  assign w_is_branch = (r_op <= 5'd5);
  assign w_target    = r_pc + r_imm;
  assign w_seq_pc    = r_pc + PC_INC[31:0];
  assign w_mis_bits  = (IALIGN == 2) ? w_target[0] : (w_target[1:0] != 2'b00);
  assign w_taken     = w_is_branch && Comparator_con_met && !w_mis_bits;
  assign w_misalign  = w_is_branch && Comparator_con_met && w_mis_bits;
  assign w_next_pc   = !w_is_branch ? 32'd0 : (w_taken ? w_target : w_seq_pc);

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      r_taken    <= 1'b0;
      r_next_pc  <= 32'd0;
      r_misalign <= 1'b0;
      r_is_slt   <= 1'b0;
      r_slt_bit  <= 1'b0;
    end else if (r_state == StWaitCmp) begin
      r_taken    <= w_taken;
      r_next_pc  <= w_next_pc;
      r_misalign <= w_misalign;
      r_is_slt   <= !w_is_branch;
      r_slt_bit  <= !w_is_branch && Comparator_con_met;
    end else if (w_release) begin
      r_taken    <= 1'b0;
      r_next_pc  <= 32'd0;
      r_misalign <= 1'b0;
      r_is_slt   <= 1'b0;
      r_slt_bit  <= 1'b0;
    end
  end

  assign busy         = (r_state != StIdle);
  assign out_valid    = (r_state == StValid);
  assign branch_taken = r_taken;
  assign flush        = out_valid && r_taken;
  assign next_pc      = r_next_pc;
  assign misalign_err = r_misalign;
  assign slt_wr_en    = out_valid && r_is_slt;
  assign slt_result   = {31'd0, r_slt_bit};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_branch_resolve_unit;

  logic        soc_clk;
  logic        reset;
  logic        dat_ready;
  logic [4:0]  decryptedOP;
  logic [31:0] cur_pc;
  logic [31:0] branch_imm;
  logic        Comparator_con_met;
  logic        out_ready;

  logic        busy, out_valid, branch_taken, flush, misalign_err, slt_wr_en;
  logic [31:0] next_pc, slt_result;
  logic        busy2, out_valid2, branch_taken2, flush2, misalign_err2, slt_wr_en2;
  logic [31:0] next_pc2, slt_result2;

  branch_resolve_unit #(.IALIGN(4), .PC_INC(4)) u_dut (
    .soc_clk(soc_clk), .reset(reset), .dat_ready(dat_ready), .decryptedOP(decryptedOP),
    .cur_pc(cur_pc), .branch_imm(branch_imm), .Comparator_con_met(Comparator_con_met),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .branch_taken(branch_taken),
    .flush(flush), .next_pc(next_pc), .misalign_err(misalign_err), .slt_wr_en(slt_wr_en),
    .slt_result(slt_result)
  );

  branch_resolve_unit #(.IALIGN(2), .PC_INC(4)) u_dut2 (
    .soc_clk(soc_clk), .reset(reset), .dat_ready(dat_ready), .decryptedOP(decryptedOP),
    .cur_pc(cur_pc), .branch_imm(branch_imm), .Comparator_con_met(Comparator_con_met),
    .out_ready(out_ready), .busy(busy2), .out_valid(out_valid2),
    .branch_taken(branch_taken2), .flush(flush2), .next_pc(next_pc2),
    .misalign_err(misalign_err2), .slt_wr_en(slt_wr_en2), .slt_result(slt_result2)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".taken"}, 32'(branch_taken), 32'd0);
    chk({nm, ".flush"}, 32'(flush), 32'd0);
    chk({nm, ".next_pc"}, next_pc, 32'd0);
    chk({nm, ".misalign"}, 32'(misalign_err), 32'd0);
    chk({nm, ".slt_wr_en"}, 32'(slt_wr_en), 32'd0);
    chk({nm, ".slt_result"}, slt_result, 32'd0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        con;
    logic        taken4;
    logic [31:0] next4;
    logic        mis4;
    logic        taken2;
    logic [31:0] next2;
    logic        mis2;
    logic        slt_en;
    logic [31:0] slt;
  } vec_t;

  vec_t vecs[9];

  // Reference result computed from the architectural rules.
  typedef struct {
    logic        taken;
    logic [31:0] next;
    logic        mis;
    logic        is_slt;
    logic        slt;
  } res_t;

  function automatic res_t calc(input logic [4:0] op, input logic [31:0] pc,
                                input logic [31:0] imm, input logic con, input int ialign);
    res_t r;
    logic [31:0] t;
    r = '{taken: 1'b0, next: 32'd0, mis: 1'b0, is_slt: 1'b0, slt: 1'b0};
    if (op <= 5) begin
      t = pc + imm;
      if (con && (t % ialign) != 0) begin
        r.mis  = 1'b1;
        r.next = pc + 32'd4;
      end else if (con) begin
        r.taken = 1'b1;
        r.next  = t;
      end else begin
        r.next = pc + 32'd4;
      end
    end else begin
      r.is_slt = 1'b1;
      r.slt    = con;
    end
    return r;
  endfunction

  function automatic logic handled(input logic [4:0] op);
    return (op <= 5) || (op == 9) || (op == 10);
  endfunction

  initial begin
    vecs[0] = '{5'd0, 32'h100, 32'h20, 1'b1, 1'b1, 32'h120, 1'b0, 1'b1, 32'h120, 1'b0,
                1'b0, 32'd0};
    vecs[1] = '{5'd1, 32'hFFFFFFFC, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'd0};
    vecs[2] = '{5'd2, 32'h200, 32'h6, 1'b1, 1'b0, 32'h204, 1'b1, 1'b1, 32'h206, 1'b0,
                1'b0, 32'd0};
    vecs[3] = '{5'd3, 32'h300, 32'hFFFFFFF0, 1'b1, 1'b1, 32'h2F0, 1'b0, 1'b1, 32'h2F0, 1'b0,
                1'b0, 32'd0};
    vecs[4] = '{5'd4, 32'h400, 32'h1, 1'b1, 1'b0, 32'h404, 1'b1, 1'b0, 32'h404, 1'b1,
                1'b0, 32'd0};
    vecs[5] = '{5'd5, 32'h500, 32'h2, 1'b0, 1'b0, 32'h504, 1'b0, 1'b0, 32'h504, 1'b0,
                1'b0, 32'd0};
    vecs[6] = '{5'd9, 32'h600, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'd1};
    vecs[7] = '{5'd10, 32'h700, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'd0};
    vecs[8] = '{5'd0, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 1'b0,
                1'b0, 32'd0};

    // Reset held two cycles with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dat_ready          = 1'($urandom);
      decryptedOP        = 5'($urandom);
      cur_pc             = $urandom;
      branch_imm         = $urandom;
      Comparator_con_met = 1'($urandom);
      out_ready          = 1'($urandom);
      step();
      chk_idle($sformatf("reset%0d", i));
    end
    reset = 1'b0;
    dat_ready = 1'b0;
    out_ready = 1'b1;
    step();
    chk_idle("post_reset");

    // Directed vector table, consumer always ready.
    foreach (vecs[i]) begin
      dat_ready   = 1'b1;
      decryptedOP = vecs[i].op;
      cur_pc      = vecs[i].pc;
      branch_imm  = vecs[i].imm;
      out_ready   = 1'b1;
      step();
      dat_ready          = 1'b0;
      decryptedOP        = 5'($urandom);
      cur_pc             = $urandom;
      branch_imm         = $urandom;
      Comparator_con_met = vecs[i].con;
      chk($sformatf("v%0d.wait_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d.wait_valid", i), 32'(out_valid), 32'd0);
      step();
      Comparator_con_met = 1'($urandom);
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d.taken", i), 32'(branch_taken), 32'(vecs[i].taken4));
      chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vecs[i].taken4));
      chk($sformatf("v%0d.next_pc", i), next_pc, vecs[i].next4);
      chk($sformatf("v%0d.misalign", i), 32'(misalign_err), 32'(vecs[i].mis4));
      chk($sformatf("v%0d.slt_wr_en", i), 32'(slt_wr_en), 32'(vecs[i].slt_en));
      chk($sformatf("v%0d.slt_result", i), slt_result, vecs[i].slt);
      chk($sformatf("v%0d.a2_taken", i), 32'(branch_taken2), 32'(vecs[i].taken2));
      chk($sformatf("v%0d.a2_next_pc", i), next_pc2, vecs[i].next2);
      chk($sformatf("v%0d.a2_misalign", i), 32'(misalign_err2), 32'(vecs[i].mis2));
      step();
      chk_idle($sformatf("v%0d.after", i));
    end

    // Reset during the comparator wait aborts the operation.
    dat_ready = 1'b1; decryptedOP = 5'd0; cur_pc = 32'h100; branch_imm = 32'h20;
    step();
    dat_ready = 1'b0; Comparator_con_met = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("rst_wait");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_wait.valid%0d", i), 32'(out_valid), 32'd0);
    end

    // SLTU under back-pressure; dat_ready pulses while stalled are dropped.
    dat_ready = 1'b1; decryptedOP = 5'd10; out_ready = 1'b0;
    step();
    dat_ready = 1'b0; Comparator_con_met = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      dat_ready = 1'(i != 1); decryptedOP = 5'd0; cur_pc = 32'h800; branch_imm = 32'h4;
      Comparator_con_met = 1'b0;
      chk($sformatf("bp%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.slt_wr_en", i), 32'(slt_wr_en), 32'd1);
      chk($sformatf("bp%0d.slt_result", i), slt_result, 32'd1);
      chk($sformatf("bp%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("bp%0d.next_pc", i), next_pc, 32'd0);
      step();
    end
    dat_ready = 1'b0; out_ready = 1'b1;
    chk("bp.last_valid", 32'(out_valid), 32'd1);
    step();
    chk_idle("bp.cleared");

    // Back-to-back: a new SLT accepted in the same cycle a branch result is consumed.
    dat_ready = 1'b1; decryptedOP = 5'd0; cur_pc = 32'h100; branch_imm = 32'h20;
    step();
    dat_ready = 1'b0; Comparator_con_met = 1'b1;
    step();
    chk("b2b.first_valid", 32'(out_valid), 32'd1);
    chk("b2b.first_next", next_pc, 32'h120);
    dat_ready = 1'b1; decryptedOP = 5'd9;
    step();
    dat_ready = 1'b0; Comparator_con_met = 1'b1;
    chk("b2b.gap_valid", 32'(out_valid), 32'd0);
    chk("b2b.gap_busy", 32'(busy), 32'd1);
    step();
    chk("b2b.second_valid", 32'(out_valid), 32'd1);
    chk("b2b.second_slt_en", 32'(slt_wr_en), 32'd1);
    chk("b2b.second_slt", slt_result, 32'd1);
    chk("b2b.second_taken", 32'(branch_taken), 32'd0);
    step();
    chk_idle("b2b.done");

    // Unhandled op in IDLE is ignored.
    dat_ready = 1'b1; decryptedOP = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("op7.busy%0d", i), 32'(busy), 32'd0);
      chk($sformatf("op7.valid%0d", i), 32'(out_valid), 32'd0);
    end
    dat_ready = 1'b0;

    // Randomized run against the transaction-level model.
    begin
      logic m_wait, m_valid, consumed;
      logic [4:0] m_op;
      logic [31:0] m_pc, m_imm;
      res_t r4, r2;
      m_wait = 1'b0; m_valid = 1'b0;
      m_op = '0; m_pc = '0; m_imm = '0;
      r4 = calc(5'd9, 32'd0, 32'd0, 1'b0, 4);
      r2 = r4;
      for (int c = 0; c < 600; c++) begin
        reset              = ($urandom_range(0, 49) == 0);
        dat_ready          = 1'($urandom);
        decryptedOP        = ($urandom_range(0, 3) == 0) ? 5'($urandom) :
                             5'($urandom_range(0, 11));
        cur_pc             = $urandom;
        branch_imm         = 32'($urandom_range(0, 63)) - 32'd32;
        Comparator_con_met = 1'($urandom);
        out_ready          = ($urandom_range(0, 3) != 0);
        if (reset) begin
          m_wait = 1'b0; m_valid = 1'b0;
        end else if (m_wait) begin
          r4 = calc(m_op, m_pc, m_imm, Comparator_con_met, 4);
          r2 = calc(m_op, m_pc, m_imm, Comparator_con_met, 2);
          m_wait = 1'b0; m_valid = 1'b1;
        end else begin
          consumed = m_valid && out_ready;
          if (consumed) m_valid = 1'b0;
          if (!m_valid && dat_ready && handled(decryptedOP)) begin
            m_op = decryptedOP; m_pc = cur_pc; m_imm = branch_imm; m_wait = 1'b1;
          end
        end
        step();
        chk($sformatf("rnd%0d.busy", c), 32'(busy), 32'(m_wait | m_valid));
        chk($sformatf("rnd%0d.valid", c), 32'(out_valid), 32'(m_valid));
        chk($sformatf("rnd%0d.taken", c), 32'(branch_taken), 32'(m_valid & r4.taken));
        chk($sformatf("rnd%0d.flush", c), 32'(flush), 32'(m_valid & r4.taken));
        chk($sformatf("rnd%0d.next_pc", c), next_pc, m_valid ? r4.next : 32'd0);
        chk($sformatf("rnd%0d.misalign", c), 32'(misalign_err), 32'(m_valid & r4.mis));
        chk($sformatf("rnd%0d.slt_wr_en", c), 32'(slt_wr_en), 32'(m_valid & r4.is_slt));
        chk($sformatf("rnd%0d.slt", c), slt_result, {31'd0, m_valid & r4.slt});
        chk($sformatf("rnd%0d.a2_taken", c), 32'(branch_taken2), 32'(m_valid & r2.taken));
        chk($sformatf("rnd%0d.a2_next_pc", c), next_pc2, m_valid ? r2.next : 32'd0);
        chk($sformatf("rnd%0d.a2_misalign", c), 32'(misalign_err2), 32'(m_valid & r2.mis));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
